// File: rtl/inst_fetch_queue_if.sv
// Signal bundle between the fetch queue, instruction memory and the CPU IF stage.
// master = fetch queue side, slave = memory/CPU side.
interface inst_fetch_queue_if #(
  parameter int WORD_LEN = 32
);
  logic                imem_req;
  logic [WORD_LEN-1:0] imem_addr;
  logic                imem_ack;
  logic [WORD_LEN-1:0] imem_rdata;
  logic                inst_valid;
  logic                inst_ready;
  logic [WORD_LEN-1:0] inst_out;
  logic [WORD_LEN-1:0] inst_pc;
  logic                redirect;
  logic [WORD_LEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetcher: one outstanding memory request, returned words
// buffered with their PCs in a small FIFO, flushed and restarted on redirect.
module inst_fetch_queue #(
  parameter int                  WORD_LEN = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_queue_if.master bus,
  output logic [1:0]         dbg_state
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [WORD_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [WORD_LEN-1:0] inst_mem_q [DEPTH];
  logic [WORD_LEN-1:0] pc_mem_q   [DEPTH];
  logic                issue;
  logic                push;
  logic                pop;
  logic                redirect_lsb_unused;

  assign redirect_lsb_unused = ^bus.redirect_pc[1:0];

  // CPU handshake: an entry transfers on a clock edge where inst_valid and
  // inst_ready are both high; inst_valid never depends on inst_ready.
  assign bus.inst_valid = (count_q != '0) && !bus.redirect;
  assign bus.inst_out   = inst_mem_q[rd_ptr_q];
  assign bus.inst_pc    = pc_mem_q[rd_ptr_q];
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.imem_req   = issue;
  assign dbg_state      = state_q;

  // Reset gates the request so nothing is issued while memory is held in reset.
  always_comb begin
    issue = rst && (state_q == IDLE) && (count_q < FULL_CNT) && !bus.redirect;
    push  = (state_q == WAIT) && bus.imem_ack && !bus.redirect;
    pop   = bus.inst_valid && bus.inst_ready;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    unique case (state_q)
      IDLE:    if (issue) state_d = WAIT;
      WAIT:    if (bus.imem_ack) state_d = IDLE;
               else if (bus.redirect) state_d = DROP;
      DROP:    if (bus.imem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = {bus.redirect_pc[WORD_LEN-1:2], 2'b00};
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + WORD_LEN'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
        pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      end
    end
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction fetch front-end between instructionMem and the MIPS_CPU IF stage.
- Issues sequential word fetches to instruction memory over a request/acknowledge handshake with variable latency.
- Buffers returned instructions, with their PCs, in a small FIFO.
- Presents them to the CPU over a valid/ready interface and supports branch/jump redirect with flush of stale fetches.

Parameters:
- WORD_LEN, 32, instruction and address width.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- imem_req  output  1  single-cycle fetch request pulse.
- imem_addr  output  WORD_LEN  fetch byte address; valid when imem_req=1.
- imem_ack  input  1  single-cycle response strobe, exactly one per accepted request.
- imem_rdata  input  WORD_LEN  instruction word; valid when imem_ack=1.
- inst_valid  output  1  head entry available to CPU.
- inst_ready  input  1  CPU accepts head entry.
- inst_out  output  WORD_LEN  head instruction.
- inst_pc  output  WORD_LEN  byte address of inst_out.
- redirect  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  WORD_LEN  new fetch address.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC, count=0, read/write pointers=0.
  - imem_req=0, inst_valid=0, inst_out=0, inst_pc=0, imem_addr=RESET_PC.
- Reset assertion mid-transaction abandons any outstanding request. Memory is also reset from the same rst, so no late ack is expected.
- Memory protocol:
  - A request is accepted on the single cycle imem_req=1.
  - imem_ack returns ≥1 cycle later.
  - At most one outstanding request.
- FSM states: IDLE, WAIT, DROP.
  - IDLE: if count<DEPTH and redirect=0, drive imem_req=1, imem_addr=fetch_pc, go to WAIT. Else stay in IDLE with imem_req=0.
  - WAIT: imem_req=0. On imem_ack with redirect=0:
    - write {fetch_pc, imem_rdata} at the write pointer, count+1;
    - fetch_pc += 4, wrapping modulo 2^WORD_LEN;
    - go to IDLE.
  - DROP: imem_req=0. On imem_ack, discard the data and go to IDLE. Otherwise stay in DROP.
- Issue condition: because only one request is outstanding and issue requires count<DEPTH, a returning ack always has a free slot. Overflow is impossible.
- Throughput: at most one instruction per 2 cycles with 1-cycle memory latency (IDLE→WAIT→IDLE).
- CPU side:
  - inst_valid = (count!=0) & ~redirect (combinational).
  - inst_out and inst_pc = head entry.
  - Pop occurs when inst_valid & inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pop from empty is ignored.
- Redirect (highest priority, sampled at clock edge):
  - count=0, pointers=0.
  - fetch_pc = {redirect_pc[WORD_LEN-1:2], 2'b00}.
  - No pop occurs that cycle.
  - Next state by current state:
    - IDLE: next state IDLE. No request is issued in the redirect cycle; the first request goes to the new PC in the following cycle.
    - WAIT with no ack that cycle: next state DROP.
    - WAIT with ack the same cycle: data discarded, next state IDLE.
    - DROP: stays in DROP, or goes to IDLE if ack arrives that cycle.
- Redirect asserted in consecutive cycles: the last redirect_pc wins.
- Latency from rst release, with a 1-cycle memory: req in cycle 0, ack in cycle 1, inst_valid=1 in cycle 2.

Test Plan:
- Reset/sequential fetch: release rst, 1-cycle memory, inst_ready=1 → imem_addr sequence 0,4,8,12; inst_pc matches; inst_out equals memory contents; inst_valid first asserts 2 cycles after release.
- Backpressure/full: inst_ready=0, memory returns 0x20080005 at address 0 → exactly 4 requests (0,4,8,12), then imem_req stays 0. Raising inst_ready drains in order; fetching resumes at 16.
- Redirect in IDLE: queue holds PCs 0,4; pulse redirect with redirect_pc=0x40 → inst_valid=0 next cycle, next imem_addr=0x40, first delivered inst_pc=0x40.
- Redirect during outstanding fetch: 3-cycle memory, redirect to 0x100 one cycle after req → state DROP; late ack data is not enqueued; next request at 0x100.
- Redirect coincident with ack, and unaligned target: redirect_pc=0x103 on the ack cycle → ack data dropped, next imem_addr=0x100.
- Async reset mid-WAIT: drive rst=0 between clock edges → imem_req and inst_valid go 0 immediately; after release, first imem_addr=RESET_PC.
